// File: rtl/lc3_pkg.sv
// lc3_pkg: shared widths and memory-interface FSM states for the LC-3 datapath slice.
package lc3_pkg;
  localparam int LC3_DATA_W = 16;
  localparam int LC3_MEM_ADDR_W = 7;
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_CAP, WR_REQ, DONE} lc3_state_e;
endpackage

// File: rtl/lc3_wait_cnt.sv
// lc3_wait_cnt: loadable saturating down-counter with a zero flag.
module lc3_wait_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         dec_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] cnt_o,
  output logic         zero_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? load_val_i : (dec_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/lc3_mem_ctrl.sv
// lc3_mem_ctrl: MAR/MDR stage sequencing read/write strobes into synchronous memory.
module lc3_mem_ctrl
  import lc3_pkg::*;
#(
  parameter int DATA_W      = LC3_DATA_W,
  parameter int ADDR_W      = LC3_MEM_ADDR_W,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              ld_mar,
  input  logic              ld_mdr,
  input  logic              mio_en,
  input  logic              r_w,
  output logic [DATA_W-1:0] mar_out,
  output logic [DATA_W-1:0] mdr_out,
  output logic              mem_ready,
  output logic              addr_fault,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_d,
  input  logic [DATA_W-1:0] mem_q
);
  localparam int CW = 4;
  localparam logic [CW-1:0] WS = CW'(WAIT_STATES);
  lc3_state_e state_q, state_d;
  logic [DATA_W-1:0] mar_q, mar_d, mdr_q, mdr_d;
  logic req_ld_q, req_ld_d, fault_q, fault_d;
  logic cnt_load, cnt_dec, cnt_zero, hi_bits;
  logic [CW-1:0] cnt;
  lc3_wait_cnt #(.W(CW)) u_cnt (
    .clk(clk), .rst(rst), .load_i(cnt_load), .dec_i(cnt_dec),
    .load_val_i(WS), .cnt_o(cnt), .zero_o(cnt_zero)
  );
  assign hi_bits = (mar_q[DATA_W-1:ADDR_W] != '0);
  always_comb begin
    state_d  = state_q;
    mar_d    = mar_q;
    mdr_d    = mdr_q;
    req_ld_d = req_ld_q;
    fault_d  = fault_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    if ((state_q == IDLE || state_q == DONE) && !mio_en) begin
      mar_d = ld_mar ? bus_in : mar_q;
      mdr_d = ld_mdr ? bus_in : mdr_q;
    end
    case (state_q)
      IDLE: if (mio_en) begin
        req_ld_d = ld_mdr;
        fault_d  = hi_bits;
        cnt_load = 1'b1;
        state_d  = hi_bits ? DONE : r_w ? WR_REQ : RD_REQ;
        // a faulting load still delivers a defined value to MDR
        if (hi_bits && !r_w && ld_mdr) mdr_d = '0;
      end
      RD_REQ: begin
        cnt_dec = 1'b1;
        state_d = cnt_zero ? RD_CAP : RD_REQ;
      end
      RD_CAP: begin
        mdr_d   = req_ld_q ? mem_q : mdr_q;
        state_d = DONE;
      end
      WR_REQ: begin
        cnt_dec = 1'b1;
        state_d = cnt_zero ? DONE : WR_REQ;
      end
      DONE:    state_d = mio_en ? DONE : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mar_q    <= '0;
      mdr_q    <= '0;
      req_ld_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      mar_q    <= mar_d;
      mdr_q    <= mdr_d;
      req_ld_q <= req_ld_d;
      fault_q  <= fault_d;
    end
  end
  assign mem_re     = (state_q == RD_REQ);
  // the counter still holds its load value only during the first write cycle
  assign mem_we     = (state_q == WR_REQ) && (cnt == WS);
  assign mem_ready  = (state_q == DONE);
  assign addr_fault = fault_q;
  assign mar_out    = mar_q;
  assign mdr_out    = mdr_q;
  assign mem_raddr  = mar_q[ADDR_W-1:0];
  assign mem_waddr  = mar_q[ADDR_W-1:0];
  assign mem_d      = mdr_q;
endmodule
